phi_omega_ladder_gen: RTL

//  Generates the five band omega_dt words (theta, alpha, beta1, beta2, gamma) as a geometric ladder

---
 rtl/phi_omega_ladder_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/phi_omega_ladder_gen.sv
// Five-band geometric omega ladder: theta * r^k for k=0..4, r = PHI_Q + ratio_offset.
// One shared multiplier steps through alpha, beta1, beta2 and gamma; outputs commit atomically.
module phi_omega_ladder_gen #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 14,
  parameter int PHI_Q = 26510
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] omega_base,
  input  logic signed [WIDTH-1:0] ratio_offset,
  output logic signed [WIDTH-1:0] omega_theta,
  output logic signed [WIDTH-1:0] omega_alpha,
  output logic signed [WIDTH-1:0] omega_beta1,
  output logic signed [WIDTH-1:0] omega_beta2,
  output logic signed [WIDTH-1:0] omega_gamma,
  output logic                    busy,
  output logic                    done,
  output logic                    sat
);

  typedef enum logic [2:0] {IDLE, S_A, S_B1, S_B2, S_G} state_t;

  localparam logic signed [WIDTH:0]     PHI_EXT = (WIDTH+1)'(PHI_Q);
  localparam logic signed [WIDTH:0]     R_MAX   = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MAX   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN   = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] t_q, t_d, work_q, work_d, r_q, r_d;
  logic signed [WIDTH-1:0] a_q, a_d, b1_q, b1_d, b2_q, b2_d;
  logic signed [WIDTH-1:0] th_q, th_d, al_q, al_d, be1_q, be1_d, be2_q, be2_d, ga_q, ga_d;
  logic sat_run_q, sat_run_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;

  logic signed [WIDTH:0]     ratio_sum;
  logic signed [WIDTH-1:0]   ratio_clamped;
  logic                      ratio_sat;
  logic signed [2*WIDTH-1:0] prod, shifted;
  logic signed [WIDTH-1:0]   step_val;
  logic                      step_sat;

  always_comb begin
    ratio_sum     = PHI_EXT + (WIDTH+1)'(ratio_offset);
    ratio_clamped = ratio_sum[WIDTH-1:0];
    ratio_sat     = 1'b0;
    if (ratio_sum[WIDTH]) begin
      ratio_clamped = '0;
      ratio_sat     = 1'b1;
    end else if (ratio_sum > R_MAX) begin
      ratio_clamped = W_MAX;
      ratio_sat     = 1'b1;
    end
  end

  // Arithmetic shift of the full product gives floor division by 2^FRAC.
  always_comb begin
    prod     = (2*WIDTH)'(work_q) * (2*WIDTH)'(r_q);
    shifted  = prod >>> FRAC;
    step_val = shifted[WIDTH-1:0];
    step_sat = 1'b0;
    if (shifted > P_MAX) begin
      step_val = W_MAX;
      step_sat = 1'b1;
    end else if (shifted < P_MIN) begin
      step_val = W_MIN;
      step_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;  t_d = t_q;  work_d = work_q;  r_d = r_q;
    a_d = a_q;  b1_d = b1_q;  b2_d = b2_q;
    th_d = th_q;  al_d = al_q;  be1_d = be1_q;  be2_d = be2_q;  ga_d = ga_q;
    sat_run_d = sat_run_q;  busy_d = busy_q;  sat_d = sat_q;
    done_d = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: if (start) begin
          t_d       = omega_base;
          work_d    = omega_base;
          r_d       = ratio_clamped;
          sat_run_d = ratio_sat;
          busy_d    = 1'b1;
          state_d   = S_A;
        end
        S_A: begin
          work_d = step_val;  a_d = step_val;
          sat_run_d = sat_run_q | step_sat;
          state_d = S_B1;
        end
        S_B1: begin
          work_d = step_val;  b1_d = step_val;
          sat_run_d = sat_run_q | step_sat;
          state_d = S_B2;
        end
        S_B2: begin
          work_d = step_val;  b2_d = step_val;
          sat_run_d = sat_run_q | step_sat;
          state_d = S_G;
        end
        S_G: begin
          th_d = t_q;  al_d = a_q;  be1_d = b1_q;  be2_d = b2_q;  ga_d = step_val;
          sat_d   = sat_run_q | step_sat;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;  work_q <= '0;  r_q <= '0;
      a_q <= '0;  b1_q <= '0;  b2_q <= '0;
      th_q <= '0;  al_q <= '0;  be1_q <= '0;  be2_q <= '0;  ga_q <= '0;
      sat_run_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;  work_q <= work_d;  r_q <= r_d;
      a_q <= a_d;  b1_q <= b1_d;  b2_q <= b2_d;
      th_q <= th_d;  al_q <= al_d;  be1_q <= be1_d;  be2_q <= be2_d;  ga_q <= ga_d;
      sat_run_q <= sat_run_d;  busy_q <= busy_d;  done_q <= done_d;  sat_q <= sat_d;
    end
  end

  assign omega_theta = th_q;
  assign omega_alpha = al_q;
  assign omega_beta1 = be1_q;
  assign omega_beta2 = be2_q;
  assign omega_gamma = ga_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sat         = sat_q;

endmodule
